// File: rtl/gonso_wb_pkg.sv
// Shared types and widths for the gonso Wishbone register bank.
package gonso_wb_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_SEL_W  = 4;
  localparam int unsigned WB_ADR_W  = 32;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned CNT_W     = 3;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef enum logic [1:0] {HIT_RW, HIT_RO, MISS} hit_t;

  typedef struct packed {
    hit_t             kind;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // Everything a transfer needs once the request has been accepted.
  typedef struct packed {
    logic                 we;
    logic [WB_SEL_W-1:0]  sel;
    logic [WB_DATA_W-1:0] dat;
    dec_t                 dec;
  } txn_t;

endpackage

// File: rtl/gonso_wb_regbank_if.sv
// Wishbone slave-side bus bundle between the user-project port and the register bank.
interface gonso_wb_regbank_if;
  import gonso_wb_pkg::*;

  logic                 wbs_cyc_i;
  logic                 wbs_stb_i;
  logic [WB_ADR_W-1:0]  wbs_adr_i;
  logic                 wbs_we_i;
  logic [WB_DATA_W-1:0] wbs_dat_i;
  logic [WB_SEL_W-1:0]  wbs_sel_i;
  logic [WB_DATA_W-1:0] wbs_dat_o;
  logic                 wbs_ack_o;
  logic                 wbs_err_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i, wbs_sel_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i, wbs_sel_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o
  );

endinterface

// File: rtl/gonso_wb_decode.sv
// Combinational byte-address to {RW/RO/miss, slot index} decoder for the register window.
module gonso_wb_decode
  import gonso_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3003_0000,
  parameter int unsigned NUM_RW    = 4,
  parameter int unsigned NUM_RO    = 2
) (
  input  logic [WB_ADR_W-1:0] adr,
  output dec_t                dec
);

  localparam int unsigned NUM_SLOT = NUM_RW + NUM_RO;

  logic [29:0] off;

  // Addresses below the base would wrap to a huge offset; reject them explicitly.
  always_comb begin
    off = 30'((adr - BASE_ADDR) >> 2);
    dec = '{kind: MISS, idx: '0};
    if ((adr >= BASE_ADDR) && (adr[1:0] == 2'b00)) begin
      if (off < 30'(NUM_RW)) begin
        dec = '{kind: HIT_RW, idx: IDX_W'(off)};
      end else if (off < 30'(NUM_SLOT)) begin
        dec = '{kind: HIT_RO, idx: IDX_W'(off - 30'(NUM_RW))};
      end
    end
  end

endmodule

// File: rtl/gonso_wb_regbank.sv
// Wishbone slave register bank: RW control registers, RO status registers,
// programmable ack latency, error termination and per-register write pulses.
module gonso_wb_regbank
  import gonso_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3003_0000,
  parameter int unsigned NUM_RW      = 4,
  parameter int unsigned NUM_RO      = 2,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] RESET_VAL   = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  gonso_wb_regbank_if.slave        wb,
  output logic [NUM_RW*DATA_W-1:0] reg_q,
  output logic [NUM_RW-1:0]        reg_wr_pulse,
  input  logic [((NUM_RO == 0) ? 1 : NUM_RO*DATA_W)-1:0] status_i
);

  localparam int unsigned NB = DATA_W / 8;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic                capture, fire, bad, commit;
  dec_t                dec;
  txn_t                live, cap, cur;
  logic [DATA_W-1:0]   regs [NUM_RW];
  logic [WB_DATA_W-1:0] rd_word;
  logic [WB_DATA_W-1:0] rdata_q;
  logic                ack_q, err_q;

  gonso_wb_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_RW    (NUM_RW),
    .NUM_RO    (NUM_RO)
  ) u_dec (
    .adr (wb.wbs_adr_i),
    .dec (dec)
  );

  // With no wait states the response fires straight from IDLE on live inputs.
  always_comb begin
    live = '{we: wb.wbs_we_i, sel: wb.wbs_sel_i, dat: wb.wbs_dat_i, dec: dec};
    cur  = (state == IDLE) ? live : cap;
  end

  assign bad    = (cur.dec.kind == MISS) || ((cur.dec.kind == HIT_RO) && cur.we);
  assign commit = fire && !bad && cur.we && (cur.dec.kind == HIT_RW);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    fire     = 1'b0;
    case (state)
      IDLE: begin
        if (wb.wbs_cyc_i && wb.wbs_stb_i) begin
          capture = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nx = RESP;
            fire     = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_W'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        if (!wb.wbs_cyc_i) begin
          state_nx = IDLE;
        end else if (cnt == CNT_W'(1)) begin
          state_nx = RESP;
          fire     = 1'b1;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned k = 0; k < NUM_RW; k++) begin
      if ((cur.dec.kind == HIT_RW) && (cur.dec.idx == IDX_W'(k))) rd_word[DATA_W-1:0] = regs[k];
    end
    for (int unsigned k = 0; k < NUM_RO; k++) begin
      if ((cur.dec.kind == HIT_RO) && (cur.dec.idx == IDX_W'(k)))
        rd_word[DATA_W-1:0] = status_i[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      cap     <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ack_q <= fire && !bad;
      err_q <= fire && bad;
      if (capture) cap <= live;
      if (fire) begin
        if (bad)          rdata_q <= '0;
        else if (!cur.we) rdata_q <= rd_word;
      end
    end
  end

  // Byte-lane commit on the ack edge; lanes beyond the register width are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_RW; k++) regs[k] <= RESET_VAL[DATA_W-1:0];
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (commit) begin
        for (int unsigned k = 0; k < NUM_RW; k++) begin
          if (cur.dec.idx == IDX_W'(k)) begin
            for (int unsigned b = 0; b < NB; b++) begin
              if (cur.sel[b]) regs[k][b*8 +: 8] <= cur.dat[b*8 +: 8];
            end
            reg_wr_pulse[k] <= |cur.sel[NB-1:0];
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RW; k++) begin : g_q
    assign reg_q[k*DATA_W +: DATA_W] = regs[k];
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_err_o = err_q;
  assign wb.wbs_dat_o = rdata_q;

endmodule

// File: tb/tb_gonso_wb_regbank.sv
// Bench for gonso_wb_regbank: three instances (no wait states, 3 wait states, 16-bit)
// checked every cycle against a transaction-level model plus literal spot checks.
module tb_gonso_wb_regbank;

  localparam logic [31:0] BASE = 32'h3003_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cyc, stb, we;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  int          tgt;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  int          ws [3] = '{0, 3, 0};
  int          dw [3] = '{32, 32, 16};
  logic [31:0] rv [3] = '{32'h0, 32'h0000_5A5A, 32'h0};

  logic [63:0] stat01 = {32'hCAFE_0123, 32'h0000_00A5};
  logic [31:0] stat2  = {16'h1234, 16'h00A5};

  logic [127:0] q0, q1;
  logic [63:0]  q2;
  logic [3:0]   p0, p1, p2;

  gonso_wb_regbank_if if0 ();
  gonso_wb_regbank_if if1 ();
  gonso_wb_regbank_if if2 ();

  assign if0.wbs_cyc_i = cyc && (tgt == 0);
  assign if0.wbs_stb_i = stb && (tgt == 0);
  assign if0.wbs_adr_i = adr;
  assign if0.wbs_we_i  = we;
  assign if0.wbs_dat_i = dat;
  assign if0.wbs_sel_i = sel;
  assign if1.wbs_cyc_i = cyc && (tgt == 1);
  assign if1.wbs_stb_i = stb && (tgt == 1);
  assign if1.wbs_adr_i = adr;
  assign if1.wbs_we_i  = we;
  assign if1.wbs_dat_i = dat;
  assign if1.wbs_sel_i = sel;
  assign if2.wbs_cyc_i = cyc && (tgt == 2);
  assign if2.wbs_stb_i = stb && (tgt == 2);
  assign if2.wbs_adr_i = adr;
  assign if2.wbs_we_i  = we;
  assign if2.wbs_dat_i = dat;
  assign if2.wbs_sel_i = sel;

  logic        ack_v [3];
  logic        err_v [3];
  logic [31:0] dat_v [3];
  logic [3:0]  pul_v [3];
  assign ack_v[0] = if0.wbs_ack_o;  assign err_v[0] = if0.wbs_err_o;  assign dat_v[0] = if0.wbs_dat_o;
  assign ack_v[1] = if1.wbs_ack_o;  assign err_v[1] = if1.wbs_err_o;  assign dat_v[1] = if1.wbs_dat_o;
  assign ack_v[2] = if2.wbs_ack_o;  assign err_v[2] = if2.wbs_err_o;  assign dat_v[2] = if2.wbs_dat_o;
  assign pul_v[0] = p0;  assign pul_v[1] = p1;  assign pul_v[2] = p2;

  gonso_wb_regbank #(.WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .wb(if0), .reg_q(q0), .reg_wr_pulse(p0), .status_i(stat01));
  gonso_wb_regbank #(.WAIT_STATES(3), .RESET_VAL(32'h0000_5A5A)) u1 (
    .clk(clk), .rst_n(rst_n), .wb(if1), .reg_q(q1), .reg_wr_pulse(p1), .status_i(stat01));
  gonso_wb_regbank #(.DATA_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .wb(if2), .reg_q(q2), .reg_wr_pulse(p2), .status_i(stat2));

  // Model state: register contents, held read data and the expected pulses this cycle.
  logic [31:0] m_reg [3][4];
  logic [31:0] exp_dat [3];
  bit          exp_ack [3];
  bit          exp_err [3];
  logic [3:0]  exp_pulse [3];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic logic [31:0] get_q(input int i, input int k);
    case (i)
      0:       return q0[k*32 +: 32];
      1:       return q1[k*32 +: 32];
      default: return {16'h0, q2[k*16 +: 16]};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) m_reg[i][k] = (dw[i] == 32) ? rv[i] : {16'h0, rv[i][15:0]};
      exp_dat[i] = '0;  exp_ack[i] = 1'b0;  exp_err[i] = 1'b0;  exp_pulse[i] = '0;
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("ack[%0d]", i), 32'(ack_v[i]), 32'(exp_ack[i]));
        check($sformatf("err[%0d]", i), 32'(err_v[i]), 32'(exp_err[i]));
        check($sformatf("dat_o[%0d]", i), dat_v[i], exp_dat[i]);
        check($sformatf("pulse[%0d]", i), 32'(pul_v[i]), 32'(exp_pulse[i]));
        for (int k = 0; k < 4; k++) check($sformatf("reg_q[%0d][%0d]", i, k), get_q(i, k), m_reg[i][k]);
      end
    end
  end

  // One transfer on instance t; drop>0 abandons the cycle after that many edges.
  task automatic xfer(input int t, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int drop, output logic [31:0] rd);
    logic [31:0] diff, val;
    int off, kind, nb;
    bit isbad, anyl;
    diff = a - BASE;
    off  = int'(diff >> 2);
    if ((a < BASE) || (a[1:0] != 2'b00) || (off >= 6)) kind = 2;
    else if (off < 4) kind = 0;
    else kind = 1;
    isbad = (kind == 2) || ((kind == 1) && w);
    @(negedge clk);
    tgt = t; cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    rd = '0;
    if (drop > 0) begin
      repeat (drop) @(posedge clk);
      #1;
      cyc = 1'b0; stb = 1'b0;
      repeat (ws[t] + 3) @(posedge clk);
      #1;
      return;
    end
    repeat (ws[t] + 1) @(posedge clk);
    #1;
    val = '0;
    if (kind == 0) val = m_reg[t][off];
    else if (kind == 1) val = (t == 2) ? {16'h0, stat2[(off-4)*16 +: 16]} : stat01[(off-4)*32 +: 32];
    if (isbad) begin
      exp_err[t] = 1'b1;
      exp_dat[t] = '0;
    end else begin
      exp_ack[t] = 1'b1;
      if (!w) exp_dat[t] = val;
      else begin
        anyl = 1'b0;
        nb   = dw[t] / 8;
        for (int b = 0; b < nb; b++) begin
          if (s[b]) begin
            m_reg[t][off][b*8 +: 8] = d[b*8 +: 8];
            anyl = 1'b1;
          end
        end
        exp_pulse[t][off] = anyl;
      end
    end
    rd = dat_v[t];
    @(posedge clk);
    #1;
    exp_ack[t] = 1'b0; exp_err[t] = 1'b0; exp_pulse[t] = '0;
    cyc = 1'b0; stb = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0; tgt = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    started = 1'b1;
    check("rst u0 reg0", get_q(0, 0), 32'h0);
    check("rst u1 reg3", get_q(1, 3), 32'h0000_5A5A);

    for (int k = 0; k < 4; k++) begin
      xfer(0, 1'b0, BASE + 32'(4*k), 32'h0, 4'hF, 0, rd);
      check($sformatf("rst read slot%0d", k), rd, 32'h0);
    end

    xfer(0, 1'b1, BASE + 32'h4, 32'h1122_3344, 4'hF, 0, rd);
    xfer(0, 1'b1, BASE + 32'h4, 32'hDEAD_BEEF, 4'b0101, 0, rd);
    check("lane write reg1", get_q(0, 1), 32'h11AD_33EF);
    xfer(0, 1'b0, BASE + 32'h4, 32'h0, 4'h0, 0, rd);
    check("lane readback", rd, 32'h11AD_33EF);

    xfer(1, 1'b0, BASE + 32'h10, 32'h0, 4'hF, 0, rd);
    check("ws3 ro read", rd, 32'h0000_00A5);
    xfer(0, 1'b0, BASE + 32'h14, 32'h0, 4'hF, 0, rd);
    check("ro slot5 read", rd, 32'hCAFE_0123);

    xfer(0, 1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF, 0, rd);
    xfer(0, 1'b1, BASE + 32'h40, 32'hFFFF_FFFF, 4'hF, 0, rd);
    xfer(0, 1'b1, BASE + 32'h2,  32'hFFFF_FFFF, 4'hF, 0, rd);
    xfer(0, 1'b0, BASE + 32'h18, 32'h0, 4'hF, 0, rd);
    xfer(0, 1'b0, BASE - 32'h4,  32'h0, 4'hF, 0, rd);
    check("err keeps reg1", get_q(0, 1), 32'h11AD_33EF);

    xfer(0, 1'b1, BASE + 32'h8, 32'hFFFF_FFFF, 4'h0, 0, rd);
    check("sel0 keeps reg2", get_q(0, 2), 32'h0);

    xfer(1, 1'b1, BASE, 32'h1111_1111, 4'hF, 1, rd);
    check("drop keeps reg0", get_q(1, 0), 32'h0000_5A5A);
    xfer(1, 1'b1, BASE + 32'h8, 32'h1234_5678, 4'hF, 0, rd);
    check("ws3 write reg2", get_q(1, 2), 32'h1234_5678);

    @(negedge clk);
    tgt = 1; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h8; dat = 32'hFFFF_0000; sel = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("mid-wait reset u1 reg2", get_q(1, 2), 32'h0000_5A5A);
    check("mid-wait reset u0 reg1", get_q(0, 1), 32'h0);

    xfer(2, 1'b1, BASE, 32'hFFFF_FFFF, 4'hF, 0, rd);
    check("dw16 write", get_q(2, 0), 32'h0000_FFFF);
    xfer(2, 1'b0, BASE, 32'h0, 4'hF, 0, rd);
    check("dw16 read", rd, 32'h0000_FFFF);
    xfer(2, 1'b1, BASE, 32'h0, 4'b1100, 0, rd);
    check("dw16 high lanes ignored", get_q(2, 0), 32'h0000_FFFF);
    xfer(2, 1'b0, BASE + 32'h10, 32'h0, 4'hF, 0, rd);
    check("dw16 ro read", rd, 32'h0000_00A5);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
